conv_feeder: RTL and testbench
==============================

# conv_feeder

Frame-buffering driver for the 3x3 `conv` edge-detection core. It accepts one IMG_W x IMG_H 8-bit image in raster order over a valid/ready pixel stream and stores it locally. It then walks every fully-inside 3x3 window, loading nine pixels into the core over its `data_in/row_in/col_in/data` load port, triggering one compute cycle, and returning each clamped result on a valid/ready result stream. It sits between the image source and the downstream edge-map collector.

## Interface
- IMG_W, 8, image width in pixels (≥3)
- IMG_H, 8, image height in pixels (≥3)
- clk  in  1  single system clock, all logic on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- pix_valid  in  1  source has a pixel on pix_data
- pix_ready  out  1  feeder accepts a pixel this cycle
- pix_data  in  8  pixel value, raster order (row 0 col 0 first)
- data_in  out  1  to core: 1 = load cycle, 0 = compute cycle
- row_in  out  2  to core: window row 0..2
- col_in  out  2  to core: window column 0..2
- data  out  8 signed  to core: pixel value (bit pattern of stored pixel, unmodified)
- conv_out  in  8 signed  from core: registered, clamped result
- res_valid  out  1  result available on res_data
- res_ready  in  1  collector accepts result
- res_data  out  8  result for current window
- res_last  out  1  asserted with res_valid on the final window of the frame
- busy  out  1  high in every state except LOAD

## Operation
- Storage: IMG_W*IMG_H x 8-bit array, written only in LOAD; not cleared by reset.
- Window origin (r,c): r = 0..IMG_H-3, c = 0..IMG_W-3, c fastest. No padding; (IMG_H-2)*(IMG_W-2) results per frame.
- States: LOAD, WRITE, COMP, WAIT, OUT.
- LOAD: pix_ready=1; pixel stored at index count on pix_valid&&pix_ready, count increments. Acceptance of pixel IMG_W*IMG_H-1 -> WRITE with (r,c)=(0,0), k=0. Gaps in pix_valid stall the count only.
- WRITE: data_in=1, row_in=k/3, col_in=k%3, data=mem[r+k/3][c+k%3]; k=0..8, one per cycle. k=8 -> COMP.
- COMP: data_in=0 for exactly one cycle; core registers result on this edge -> WAIT.
- WAIT: conv_out holds result; res_data<=conv_out, res_valid<=1, res_last<=(last window) -> OUT.
- OUT: res_valid, res_data, res_last held stable until res_ready. On res_valid&&res_ready: if last window -> LOAD (count=0); else advance (c+1, or c=0,r+1 at row end), k=0 -> WRITE.
- data_in=0 in all states except WRITE; row_in, col_in, data = 0 outside WRITE.
- Pixel bits pass to core unchanged; no sign or range conversion in the feeder.

## Timing
- Reset values: pix_ready=0 while rst_n low, 1 from first clock after release (state LOAD); data_in=0, row_in=0, col_in=0, data=0, res_valid=0, res_data=0, res_last=0, busy=0, count=0.
- Reset asserted in any state: outputs take reset values immediately (asynchronous), image must be fully reloaded; an in-flight result is discarded.
- Per window minimum 12 cycles: 9 WRITE + 1 COMP + 1 WAIT + 1 OUT (res_ready high).
- res_valid rises on the cycle after WAIT, i.e. 11 cycles after the first WRITE cycle of that window.
- Frame latency: last pixel accepted -> first res_valid = 11 cycles.
- pix_ready=0 from the cycle after the last pixel is accepted until the cycle after the final result handshake; pix_valid ignored then.
- Core sees exactly one compute cycle per window and no load cycles outside WRITE.

## Test plan
- Reset: hold rst_n low 3 cycles, release -> all outputs at reset values, pix_ready=1 next cycle, busy=0.
- Vertical ramp, IMG_W=IMG_H=8, pixel=row*10, pix_valid always high, res_ready always high, real `conv` attached -> 36 results all 80, res_last only on 36th, successive res_valid 12 cycles apart.
- Constant image (all 50) -> 36 results all 0; then second frame accepted without reset, results match.
- Load-port check, IMG_W=IMG_H=4, pixel=index -> window (1,1) drives row/col (0,0)..(2,2) with data 5,6,7,9,10,11,13,14,15, followed by one data_in=0 cycle.
- Backpressure: res_ready low 5 cycles on window 3 -> res_valid and res_data stable, no WRITE cycles, pix_ready=0; release -> window 4 loads next cycle.
- Reset mid-WRITE (k=4 of window 2) -> data_in=0 and res_valid=0 immediately, pix_ready=1 after release, reload of full frame produces correct 36 results.

Source files
------------

// File: rtl/conv_feeder.sv
// Frame buffer and window sequencer for the 3x3 conv core: store one raster image,
// then load each fully-inside 3x3 window into the core, compute once, and stream results.
module conv_feeder #(
    parameter int IMG_W = 8,
    parameter int IMG_H = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              pix_valid,
    output logic              pix_ready,
    input  logic [7:0]        pix_data,
    output logic              data_in,
    output logic [1:0]        row_in,
    output logic [1:0]        col_in,
    output logic signed [7:0] data,
    input  logic signed [7:0] conv_out,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [7:0]        res_data,
    output logic              res_last,
    output logic              busy
);

    localparam int NPIX = IMG_W * IMG_H;
    localparam int AW   = $clog2(NPIX);
    localparam int RW   = $clog2(IMG_H);
    localparam int CW   = $clog2(IMG_W);

    typedef enum logic [2:0] {LOAD, WRITE, COMP, WAIT, OUT} state_t;

    state_t        state, state_nxt;
    logic [AW-1:0] count;
    logic [RW-1:0] r;
    logic [CW-1:0] c;
    logic [1:0]    kr, kc;
    logic          started;
    logic [AW-1:0] addr;
    logic          pix_take, last_pix, last_win, k_done;
    logic [7:0]    mem [NPIX];

    assign pix_take = pix_ready && pix_valid;
    assign last_pix = (count == AW'(NPIX - 1));
    assign last_win = (r == RW'(IMG_H - 3)) && (c == CW'(IMG_W - 3));
    assign k_done   = (kr == 2'd2) && (kc == 2'd2);
    assign addr     = AW'((32'(r) + 32'(kr)) * IMG_W + 32'(c) + 32'(kc));

    // Image storage is deliberately not reset; a new frame always overwrites it.
    always_ff @(posedge clk) begin
        if (pix_take) mem[count] <= pix_data;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            LOAD:  if (pix_take && last_pix) state_nxt = WRITE;
            WRITE: if (k_done) state_nxt = COMP;
            COMP:  state_nxt = WAIT;
            WAIT:  state_nxt = OUT;
            OUT:   if (res_ready) state_nxt = last_win ? LOAD : WRITE;
            default: state_nxt = LOAD;
        endcase
    end

    // pix_ready is gated by started so it stays low while reset is held.
    always_comb begin
        pix_ready = started && (state == LOAD);
        busy      = (state != LOAD);
        data_in   = 1'b0;
        row_in    = 2'd0;
        col_in    = 2'd0;
        data      = 8'sd0;
        if (state == WRITE) begin
            data_in = 1'b1;
            row_in  = kr;
            col_in  = kc;
            data    = mem[addr];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= LOAD;
            started   <= 1'b0;
            count     <= '0;
            r         <= '0;
            c         <= '0;
            kr        <= 2'd0;
            kc        <= 2'd0;
            res_valid <= 1'b0;
            res_data  <= 8'd0;
            res_last  <= 1'b0;
        end else begin
            state   <= state_nxt;
            started <= 1'b1;
            case (state)
                LOAD: if (pix_take) begin
                    count <= last_pix ? '0 : count + 1'b1;
                    r     <= '0;
                    c     <= '0;
                    kr    <= 2'd0;
                    kc    <= 2'd0;
                end
                WRITE: begin
                    if (k_done) begin
                        kr <= 2'd0;
                        kc <= 2'd0;
                    end else if (kc == 2'd2) begin
                        kc <= 2'd0;
                        kr <= kr + 2'd1;
                    end else begin
                        kc <= kc + 2'd1;
                    end
                end
                WAIT: begin
                    res_valid <= 1'b1;
                    res_data  <= conv_out;
                    res_last  <= last_win;
                end
                OUT: if (res_ready) begin
                    res_valid <= 1'b0;
                    res_last  <= 1'b0;
                    if (last_win) begin
                        r     <= '0;
                        c     <= '0;
                        count <= '0;
                    end else if (c == CW'(IMG_W - 3)) begin
                        c <= '0;
                        r <= r + 1'b1;
                    end else begin
                        c <= c + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_conv_feeder.sv
// Directed bench for conv_feeder: an 8x8 instance driving a vertical-gradient core model,
// plus a 4x4 instance whose load port is checked pixel by pixel.
module tb_conv_feeder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst_n, pix_valid, pix_ready, data_in, res_valid, res_ready, res_last, busy;
    logic [7:0]        pix_data, res_data;
    logic [1:0]        row_in, col_in;
    logic signed [7:0] data, conv_out;

    logic              p4_valid, p4_ready, d4_in, r4_valid, r4_last, busy4;
    logic [7:0]        p4_data, r4_data;
    logic [1:0]        row4, col4;
    logic signed [7:0] data4;
    logic signed [7:0] conv4 = 8'sd0;
    logic              r4_ready = 1'b1;

    int checks = 0;
    int errors = 0;

    conv_feeder #(.IMG_W(8), .IMG_H(8)) dut (
        .clk(clk), .rst_n(rst_n), .pix_valid(pix_valid), .pix_ready(pix_ready),
        .pix_data(pix_data), .data_in(data_in), .row_in(row_in), .col_in(col_in),
        .data(data), .conv_out(conv_out), .res_valid(res_valid), .res_ready(res_ready),
        .res_data(res_data), .res_last(res_last), .busy(busy)
    );

    conv_feeder #(.IMG_W(4), .IMG_H(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .pix_valid(p4_valid), .pix_ready(p4_ready),
        .pix_data(p4_data), .data_in(d4_in), .row_in(row4), .col_in(col4),
        .data(data4), .conv_out(conv4), .res_valid(r4_valid), .res_ready(r4_ready),
        .res_data(r4_data), .res_last(r4_last), .busy(busy4)
    );

    // Core model: vertical gradient (bottom row minus top row, centre weighted 2), clamped.
    logic signed [7:0] w [4][4];

    function automatic logic signed [7:0] core_calc();
        int s;
        s = int'(w[2][0]) + 2 * int'(w[2][1]) + int'(w[2][2])
          - int'(w[0][0]) - 2 * int'(w[0][1]) - int'(w[0][2]);
        if (s > 127) return 8'sd127;
        if (s < -128) return 8'sh80;
        return 8'(s);
    endfunction

    always @(posedge clk) begin
        if (data_in) w[row_in][col_in] <= data;
        else         conv_out <= core_calc();
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    function automatic logic [7:0] pixval(input int mode, input int i);
        return (mode == 0) ? 8'((i / 8) * 10) : 8'd50;
    endfunction

    task automatic load_frame(input int mode, input bit gaps, output time t_last);
        int i, guard;
        bit acc;
        i = 0; guard = 0; t_last = 0;
        while (i < 64 && guard < 400) begin
            @(negedge clk);
            guard++;
            pix_valid = !(gaps && (guard % 5 == 0));
            pix_data  = pixval(mode, i);
            acc       = pix_valid && pix_ready;
            @(posedge clk);
            if (acc) begin
                i++;
                if (i == 64) t_last = $time;
            end
        end
        #1 pix_valid = 1'b0;
        chk("frame_loaded", i, 64);
        @(negedge clk);
        chk("pix_ready_after_frame", pix_ready, 0);
        chk("busy_after_frame", busy, 1);
    endtask

    task automatic run_results(input int expv, input int bp_win, input time t_last, input bit timing);
        int wait_n;
        time tprev;
        logic [7:0] saved;
        tprev = 0;
        for (int wn = 0; wn < 36; wn++) begin
            @(negedge clk);
            wait_n = 0;
            while (!res_valid && wait_n < 40) begin
                @(negedge clk);
                wait_n++;
            end
            if (!res_valid) begin
                chk("res_timeout", 0, 1);
                break;
            end
            if (timing) begin
                if (wn == 0) chk("frame_latency", int'(($time - t_last) / 10), 11);
                else         chk("res_spacing", int'(($time - tprev) / 10), 12);
            end
            tprev = $time;
            chk("res_data", res_data, 8'(expv));
            chk("res_last", res_last, wn == 35);
            if (wn == bp_win) begin
                res_ready = 1'b0;
                saved = res_data;
                repeat (5) begin
                    @(negedge clk);
                    chk("bp_valid", res_valid, 1);
                    chk("bp_data", res_data, saved);
                    chk("bp_no_write", data_in, 0);
                    chk("bp_pix_ready", pix_ready, 0);
                end
                res_ready = 1'b1;
                @(negedge clk);
                chk("bp_resume", {data_in, row_in, col_in}, 5'b10000);
            end
        end
        @(negedge clk);
        chk("end_pix_ready", pix_ready, 1);
        chk("end_busy", busy, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout");
        $fatal(1);
    end

    initial begin
        time tl;
        int  i, guard, nload, j;
        bit  acc;
        int  exp_tbl [9] = '{5, 6, 7, 9, 10, 11, 13, 14, 15};

        rst_n = 1'b0; pix_valid = 1'b0; pix_data = 8'd0; res_ready = 1'b1;
        p4_valid = 1'b0; p4_data = 8'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_pix_ready", pix_ready, 0);
        chk("rst_data_in", data_in, 0);
        chk("rst_row_col", {row_in, col_in}, 0);
        chk("rst_data", data, 0);
        chk("rst_res_valid", res_valid, 0);
        chk("rst_res_data", res_data, 0);
        chk("rst_res_last", res_last, 0);
        chk("rst_busy", busy, 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("pix_ready_after_rst", pix_ready, 1);
        chk("busy_after_rst", busy, 0);

        load_frame(0, 1'b0, tl);
        run_results(80, -1, tl, 1'b1);
        load_frame(1, 1'b1, tl);
        run_results(0, -1, tl, 1'b0);
        load_frame(1, 1'b0, tl);
        run_results(0, 2, tl, 1'b0);

        // Reset while the second window is mid-load.
        load_frame(0, 1'b0, tl);
        guard = 0;
        while (!res_valid && guard < 60) begin
            @(negedge clk);
            guard++;
        end
        chk("mw_first_res", res_valid, 1);
        guard = 0;
        do begin
            @(negedge clk);
            guard++;
        end while (!(data_in && row_in == 2'd1 && col_in == 2'd1) && guard < 40);
        chk("mw_at_k4", data_in, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("mw_data_in", data_in, 0);
        chk("mw_res_valid", res_valid, 0);
        chk("mw_pix_ready", pix_ready, 0);
        chk("mw_busy", busy, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("mw_pix_ready_after", pix_ready, 1);
        load_frame(0, 1'b0, tl);
        run_results(80, -1, tl, 1'b1);

        // 4x4 load-port check on window (1,1).
        i = 0; guard = 0;
        while (i < 16 && guard < 100) begin
            @(negedge clk);
            guard++;
            p4_valid = 1'b1;
            p4_data  = 8'(i);
            acc      = p4_ready;
            @(posedge clk);
            if (acc) i++;
        end
        #1 p4_valid = 1'b0;
        chk("lp_frame_loaded", i, 16);
        nload = 0; guard = 0;
        while (nload < 36 && guard < 200) begin
            @(negedge clk);
            guard++;
            if (d4_in) begin
                if (nload >= 27) begin
                    j = nload - 27;
                    chk("lp_row", row4, j / 3);
                    chk("lp_col", col4, j % 3);
                    chk("lp_data", 8'(data4), exp_tbl[j]);
                end
                nload++;
            end
        end
        chk("lp_loads", nload, 36);
        @(negedge clk);
        chk("lp_compute", d4_in, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
